dual_modulus_divider: RTL and testbench
=======================================

Name: dual_modulus_divider

Overview:
- Fractional-N feedback divider. Sits directly downstream of the second-order sigma-delta modulator and consumes its 1-bit `out` as `sd_bit`.
- Divides the VCO clock by N or N+1 each output period, where N = `n_int` and the +1 comes from `sd_bit`.
- Produces the divided clock `div_out`. `div_out` feeds the phase detector and also clocks the sigma-delta modulator.
- Also measures sigma-delta density over a fixed window of periods for verification and calibration.

Parameters:
- W, 8: width of the integer divide word `n_int`.
- WIN_LOG2, 8: log2 of the density-measurement window, counted in output periods.

Ports:
- CLK  in  1  VCO clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- enable  in  1  run request.
- n_int  in  W  integer divide ratio N.
- sd_bit  in  1  modulus select from the sigma-delta; 1 selects N+1.
- div_out  out  1  divided clock, near-50% duty.
- div_tick  out  1  one-cycle pulse on the first CLK cycle of each period.
- ratio  out  W+1  divide ratio of the current period.
- ones_count  out  WIN_LOG2+1  count of N+1 periods in the last completed window.
- win_done  out  1  one-cycle pulse when `ones_count` updates.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST. All outputs are registered.

Reset:
- On a CLK edge with RST=1: state=IDLE; count, ratio, div_out, div_tick, ones_count, win_done, the window counter and the ones accumulator all go to 0.
- RST mid-period aborts the period immediately. No partial-window result is reported.

Ratio computation:
- Rn = n_int + sd_bit, computed in W+1 bits.
- If Rn < 2, then Rn = 2. Maximum Rn is 2^W.
- H = Rn >> 1.

State machine, states IDLE and RUN:
- IDLE, enable=0: hold all outputs at 0.
- IDLE, enable=1 at an edge: sample n_int and sd_bit, then:
  - ratio <= Rn; count <= Rn-1;
  - div_out <= 1; div_tick <= 1;
  - state <= RUN.
- RUN, count != 0:
  - count <= count-1; div_tick <= 0;
  - div_out <= ((count-1) >= ratio-H), where H is taken from the current ratio.
- RUN, count == 0, enable=1: same reload as IDLE→RUN. sd_bit and n_int are sampled only on this cycle, so changes at other times have no effect.
- RUN, count == 0, enable=0: state <= IDLE; div_out <= 0; div_tick <= 0.
- Deasserting enable mid-period always completes the current period.

Timing:
- Each period is exactly `ratio` CLK cycles.
- div_out is high for H cycles, then low for ratio-H cycles.
- div_tick coincides with the rising edge of div_out.
- Sampling sd_bit at the end of the period guarantees it is stable: the modulator updates it on the div_out rising edge, a full period earlier.

Density window:
- Each reload in RUN increments the window counter and adds the sampled sd_bit to the accumulator. The IDLE→RUN load counts as a reload.
- When the window counter reaches 2^WIN_LOG2 periods:
  - ones_count <= accumulator, including the current sd_bit;
  - win_done pulses for one cycle, on the same cycle as that period's div_tick;
  - the accumulator and window counter clear.
- Entering IDLE also clears the accumulator and window counter, with no win_done.

Decomposition:
- Shared package pll_pkg holds:
  - the state enum (IDLE, RUN);
  - the MIN_RATIO=2 constant;
  - the ratio width function W+1.
- Natural sub-module: sd_density_meter. It contains the window counter, the accumulator, and generates ones_count and win_done. It is driven by a reload strobe plus sd_bit.

Test Plan:
1. RST for 2 cycles, then enable=1, n_int=8, sd_bit=0 → div_tick every 8 cycles starting on the enable edge; div_out 4 high / 4 low; ratio=8.
2. n_int=8, sd_bit=1 held → period 9; div_out 4 high / 5 low; ratio=9.
3. sd_bit alternating 1/0 per period, n_int=8 → periods alternate 9/8. After 256 periods, win_done pulses once with ones_count=128.
4. Clamp and extremes:
   - n_int=0, sd_bit=0 → ratio=2;
   - n_int=1, sd_bit=1 → ratio=2, div_out 1 high / 1 low;
   - n_int=255, sd_bit=1 → ratio=256, 128/128.
5. enable dropped with count=3 → the remaining 4 cycles complete, then IDLE with div_out=0 and no further ticks. Re-enable → new period starts on that edge.
6. RST asserted mid-period and mid-window → all outputs 0 on the next cycle, no win_done. On restart, the first window reports only post-reset periods.

Source files
------------

// File: rtl/dual_modulus_divider_pkg.sv
// pll_pkg: shared FSM state, minimum divide ratio and ratio-width helper for the fractional-N divider
package pll_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int MIN_RATIO = 2;
  function automatic int ratio_w(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/dual_modulus_divider_if.sv
// dual_modulus_divider_if: divider bus; inputs enable/n_int/sd_bit, outputs div_out/div_tick/ratio/ones_count/win_done
interface dual_modulus_divider_if import pll_pkg::*; #(parameter int W = 8, parameter int WIN_LOG2 = 8);
  logic enable;
  logic [W-1:0] n_int;
  logic sd_bit;
  logic div_out;
  logic div_tick;
  logic [ratio_w(W)-1:0] ratio;
  logic [WIN_LOG2:0] ones_count;
  logic win_done;
  modport master (output enable, n_int, sd_bit, input div_out, div_tick, ratio, ones_count, win_done);
  modport slave (input enable, n_int, sd_bit, output div_out, div_tick, ratio, ones_count, win_done);
endinterface

// File: rtl/dual_modulus_divider_sd_density_meter.sv
// sd_density_meter: counts N+1 periods over 2^WIN_LOG2 reloads; in CLK/RST/i_reload/i_clr/i_sd_bit, out o_ones_count/o_win_done
module sd_density_meter #(parameter int WIN_LOG2 = 8) (
  input  logic CLK,
  input  logic RST,
  input  logic i_reload,
  input  logic i_clr,
  input  logic i_sd_bit,
  output logic [WIN_LOG2:0] o_ones_count,
  output logic o_win_done
);
  logic [WIN_LOG2-1:0] r_win;
  logic [WIN_LOG2:0] r_acc;
  logic [WIN_LOG2:0] w_sum;
  assign w_sum = r_acc + (WIN_LOG2+1)'(i_sd_bit);
  always_ff @(posedge CLK) begin
    if (RST || i_clr) begin
      r_win <= '0;
      r_acc <= '0;
      o_ones_count <= '0;
      o_win_done <= 1'b0;
    end else begin
      o_win_done <= 1'b0;
      if (i_reload) begin
        if (&r_win) begin
          o_ones_count <= w_sum;
          o_win_done <= 1'b1;
          r_acc <= '0;
          r_win <= '0;
        end else begin
          r_acc <= w_sum;
          r_win <= r_win + WIN_LOG2'(1);
        end
      end
    end
  end
endmodule

// File: rtl/dual_modulus_divider.sv
// dual_modulus_divider: divides CLK by N or N+1 per period from sd_bit; in CLK/RST/bus.enable/n_int/sd_bit, out bus.div_out/div_tick/ratio/ones_count/win_done
module dual_modulus_divider import pll_pkg::*; #(parameter int W = 8, parameter int WIN_LOG2 = 8) (
  input logic CLK,
  input logic RST,
  dual_modulus_divider_if.slave bus
);
  localparam int RW = ratio_w(W);
  state_t r_state;
  logic [RW-1:0] r_count, r_ratio;
  logic r_div_out, r_div_tick;
  logic [RW-1:0] w_rn_raw, w_rn, w_cm1, w_low;
  logic w_end, w_reload, w_clr;
  assign w_rn_raw = RW'(bus.n_int) + RW'(bus.sd_bit);
  assign w_rn = w_rn_raw < RW'(MIN_RATIO) ? RW'(MIN_RATIO) : w_rn_raw;
  assign w_cm1 = r_count - RW'(1);
  assign w_low = r_ratio - (r_ratio >> 1);
  assign w_end = r_state == IDLE || r_count == '0;
  assign w_reload = w_end && bus.enable;
  assign w_clr = w_end && !bus.enable;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_count <= '0;
      r_ratio <= '0;
      r_div_out <= 1'b0;
      r_div_tick <= 1'b0;
    end else if (w_reload) begin
      r_state <= RUN;
      r_ratio <= w_rn;
      r_count <= w_rn - RW'(1);
      r_div_out <= 1'b1;
      r_div_tick <= 1'b1;
    end else if (w_clr) begin
      r_state <= IDLE;
      r_count <= '0;
      r_ratio <= '0;
      r_div_out <= 1'b0;
      r_div_tick <= 1'b0;
    end else begin
      r_count <= w_cm1;
      r_div_tick <= 1'b0;
      r_div_out <= w_cm1 >= w_low;
    end
  end
  assign bus.div_out = r_div_out;
  assign bus.div_tick = r_div_tick;
  assign bus.ratio = r_ratio;
  sd_density_meter #(.WIN_LOG2(WIN_LOG2)) u_meter (
    .CLK(CLK),
    .RST(RST),
    .i_reload(w_reload),
    .i_clr(w_clr),
    .i_sd_bit(bus.sd_bit),
    .o_ones_count(bus.ones_count),
    .o_win_done(bus.win_done)
  );
endmodule

// File: tb/tb_dual_modulus_divider.sv
// tb_dual_modulus_divider: directed table-driven bench for dual_modulus_divider
module tb_dual_modulus_divider;
  typedef struct {int n; int sd; int r; int h;} vec_t;
  logic clk, rst;
  int tests, fails, mp, mo, eones;
  vec_t tbl[12];
  dual_modulus_divider_if #(.W(8), .WIN_LOG2(8)) bus ();
  dual_modulus_divider #(.W(8), .WIN_LOG2(8)) dut (.CLK(clk), .RST(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic period(input int n, input int sd, input int r, input int h, input bit last);
    int wd;
    bus.enable = 1'b1;
    bus.n_int = n[7:0];
    bus.sd_bit = sd[0];
    for (int k = 0; k < r; k++) begin
      @(negedge clk);
      wd = 0;
      if (k == 0) begin
        mp++;
        mo += sd;
        if (mp == 256) begin
          wd = 1;
          eones = mo;
          mp = 0;
          mo = 0;
        end
      end
      chk("div_tick", int'(bus.div_tick), int'(k == 0));
      chk("div_out", int'(bus.div_out), int'(k < h));
      chk("ratio", int'(bus.ratio), r);
      chk("win_done", int'(bus.win_done), wd);
      chk("ones_count", int'(bus.ones_count), eones);
      if (k == 1 && r > 2) begin
        bus.n_int = 8'($urandom);
        bus.sd_bit = ~bus.sd_bit;
      end
      if (last && k == (r >= 4 ? r - 4 : 0)) bus.enable = 1'b0;
    end
  endtask
  task automatic idle(input int cycles);
    mp = 0;
    mo = 0;
    eones = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      chk("idle_div_out", int'(bus.div_out), 0);
      chk("idle_div_tick", int'(bus.div_tick), 0);
      chk("idle_win_done", int'(bus.win_done), 0);
      chk("idle_ones_count", int'(bus.ones_count), 0);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_div_out"}, int'(bus.div_out), 0);
    chk({nm, "_div_tick"}, int'(bus.div_tick), 0);
    chk({nm, "_ratio"}, int'(bus.ratio), 0);
    chk({nm, "_ones_count"}, int'(bus.ones_count), 0);
    chk({nm, "_win_done"}, int'(bus.win_done), 0);
  endtask
  initial begin
    tests = 0;
    fails = 0;
    mp = 0;
    mo = 0;
    eones = 0;
    tbl[0] = '{8, 0, 8, 4};
    tbl[1] = '{8, 0, 8, 4};
    tbl[2] = '{8, 1, 9, 4};
    tbl[3] = '{8, 1, 9, 4};
    tbl[4] = '{0, 0, 2, 1};
    tbl[5] = '{1, 1, 2, 1};
    tbl[6] = '{1, 0, 2, 1};
    tbl[7] = '{255, 1, 256, 128};
    tbl[8] = '{255, 0, 255, 127};
    tbl[9] = '{7, 0, 7, 3};
    tbl[10] = '{3, 0, 3, 1};
    tbl[11] = '{2, 1, 3, 1};
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.n_int = 8'd0;
    bus.sd_bit = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    idle(3);
    for (int i = 0; i < 12; i++) period(tbl[i].n, tbl[i].sd, tbl[i].r, tbl[i].h, i == 11);
    idle(4);
    for (int i = 0; i < 256; i++) period(8, (i % 2 == 0) ? 1 : 0, (i % 2 == 0) ? 9 : 8, 4, i == 255);
    chk("window_ones_128", int'(bus.ones_count), 128);
    idle(6);
    period(8, 0, 8, 4, 1'b0);
    period(8, 1, 9, 4, 1'b0);
    bus.n_int = 8'd8;
    bus.sd_bit = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_reset");
    rst = 1'b0;
    mp = 0;
    mo = 0;
    eones = 0;
    for (int i = 0; i < 256; i++) period(1, 1, 2, 1, 1'b0);
    chk("window_ones_256", int'(bus.ones_count), 256);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
